// File: rtl/sdram_arbiter_pkg.sv
// Shared widths, FSM state and owner encodings
// for the two-requester SDRAM port arbiter.
package sdram_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH  = 29;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_BURST_WIDTH = 8;
  localparam int DEF_MAX_HIGH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD_READ,
    ST_DATA_READ,
    ST_WRITE
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Shares one Avalon-MM SDRAM port between a display reader (m0, high
// priority) and a rasterizer (m1, read/write); whole-burst grants.
// Ports: clock/reset; m0_* read master; m1_* read/write master;
// s_* towards the SDRAM port; readdata shared; owner = debug grantee.
module sdram_port_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int BURST_WIDTH     = DEF_BURST_WIDTH,
  parameter int MAX_HIGH_GRANTS = DEF_MAX_HIGH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [BURST_WIDTH-1:0]  m0_burstcount,
  input  logic                    m0_read,
  output logic                    m0_waitrequest,
  output logic                    m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [BURST_WIDTH-1:0]  m1_burstcount,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH-1:0]   m1_writedata,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
  output logic                    m1_waitrequest,
  output logic                    m1_readdatavalid,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic [ADDR_WIDTH-1:0]   s_address,
  output logic [BURST_WIDTH-1:0]  s_burstcount,
  output logic                    s_read,
  output logic                    s_write,
  output logic [DATA_WIDTH-1:0]   s_writedata,
  output logic [DATA_WIDTH/8-1:0] s_byteenable,
  input  logic                    s_waitrequest,
  input  logic [DATA_WIDTH-1:0]   s_readdata,
  input  logic                    s_readdatavalid,
  output logic [1:0]              owner
);

  localparam int SC_W = $clog2(MAX_HIGH_GRANTS + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_HIGH_GRANTS);
  localparam logic [BURST_WIDTH-1:0] ONE = BURST_WIDTH'(1);

  state_t                 state, state_nx;
  logic [1:0]             owner_nx;
  logic [BURST_WIDTH-1:0] beats, beats_nx;
  logic [SC_W-1:0]        starve_cnt, starve_nx;

  logic                   m1_pend;
  logic                   own_m1;
  logic                   wr_done;
  logic [BURST_WIDTH-1:0] s_len;

  assign m1_pend = m1_read | m1_write;
  assign own_m1  = (owner == OWNER_M1);
  // burstcount 0 is treated as a single beat
  assign s_len   = (s_burstcount == '0) ? ONE : s_burstcount;

  assign readdata     = s_readdata;
  assign s_address    = own_m1 ? m1_address : m0_address;
  assign s_burstcount = own_m1 ? m1_burstcount : m0_burstcount;
  assign s_writedata  = m1_writedata;
  assign s_byteenable = m1_byteenable;

  always_comb begin
    s_read           = 1'b0;
    s_write          = 1'b0;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    unique case (state)
      ST_CMD_READ: begin
        s_read = own_m1 ? m1_read : m0_read;
        if (own_m1) m1_waitrequest = s_waitrequest;
        else        m0_waitrequest = s_waitrequest;
      end
      ST_DATA_READ: begin
        m0_readdatavalid = s_readdatavalid & ~own_m1;
        m1_readdatavalid = s_readdatavalid & own_m1;
      end
      ST_WRITE: begin
        s_write        = m1_write;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    beats_nx  = beats;
    starve_nx = starve_cnt;
    wr_done   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        beats_nx = '0;
        if (m1_pend && starve_cnt == SC_MAX) begin
          owner_nx  = OWNER_M1;
          starve_nx = '0;
          state_nx  = m1_read ? ST_CMD_READ : ST_WRITE;
        end else if (m0_read) begin
          owner_nx  = OWNER_M0;
          state_nx  = ST_CMD_READ;
          // below SC_MAX here whenever m1 is pending
          starve_nx = m1_pend ? starve_cnt + 1'b1 : '0;
        end else if (m1_pend) begin
          owner_nx  = OWNER_M1;
          starve_nx = '0;
          state_nx  = m1_read ? ST_CMD_READ : ST_WRITE;
        end
      end
      ST_CMD_READ: begin
        if (!s_read) begin
          state_nx = ST_IDLE;
          owner_nx = OWNER_NONE;
        end else if (!s_waitrequest) begin
          beats_nx = s_len;
          state_nx = ST_DATA_READ;
        end
      end
      ST_DATA_READ: begin
        if (s_readdatavalid) begin
          beats_nx = beats - 1'b1;
          if (beats == ONE) begin
            state_nx = ST_IDLE;
            owner_nx = OWNER_NONE;
          end
        end
      end
      ST_WRITE: begin
        // beats==0 marks the burst's first beat
        if (s_write && !s_waitrequest) begin
          if (beats == '0) begin
            beats_nx = s_len - 1'b1;
            wr_done  = (s_len == ONE);
          end else begin
            beats_nx = beats - 1'b1;
            wr_done  = (beats == ONE);
          end
        end
        if (wr_done) begin
          state_nx = ST_IDLE;
          owner_nx = OWNER_NONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        owner_nx = OWNER_NONE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWNER_NONE;
      beats      <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      beats      <= beats_nx;
      starve_cnt <= starve_nx;
    end
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one HPS F2H SDRAM Avalon-MM port between two requesters:
  - m0: display frame-buffer reader, read-only, high priority.
  - m1: rasterizer, read/write.
- Sits between those requesters and the soc_system f2h_sdram data port, so one SDRAM port is freed for other use.
- Grants whole bursts, routes returning read beats back to their owner, and bounds how long m1 can be starved.

Parameters:
- ADDR_WIDTH, 29, Avalon word-address width.
- DATA_WIDTH, 64, data bus width; byteenable width is DATA_WIDTH/8.
- BURST_WIDTH, 8, burstcount width.
- MAX_HIGH_GRANTS, 4, consecutive m0 grants allowed while m1 waits before m1 is forced.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_WIDTH  display read address
- m0_burstcount  in  BURST_WIDTH  display burst length
- m0_read  in  1  display read request
- m0_waitrequest  out  1  stall to display
- m0_readdatavalid  out  1  display read beat valid
- m1_address  in  ADDR_WIDTH  rasterizer address
- m1_burstcount  in  BURST_WIDTH  rasterizer burst length
- m1_read  in  1  rasterizer read request
- m1_write  in  1  rasterizer write request
- m1_writedata  in  DATA_WIDTH  write data
- m1_byteenable  in  DATA_WIDTH/8  write byte enables
- m1_waitrequest  out  1  stall to rasterizer
- m1_readdatavalid  out  1  rasterizer read beat valid
- readdata  out  DATA_WIDTH  s_readdata broadcast to both requesters
- s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable  out  as above  to SDRAM port
- s_waitrequest  in  1 ; s_readdata  in  DATA_WIDTH ; s_readdatavalid  in  1  from SDRAM port
- owner  out  2  debug: 00 none, 01 m0, 10 m1

Behaviour:
- Clocking and reset:
  - One clock domain.
  - reset is asynchronous and active-high, and clears every register immediately.
- Reset values:
  - State IDLE; owner=00.
  - s_read=0, s_write=0.
  - m0_waitrequest=1, m1_waitrequest=1.
  - m*_readdatavalid=0.
  - Beat counter=0, starvation counter=0.
- States:
  - IDLE, CMD_READ, DATA_READ, WRITE.
  - Encoded in a registered state; owner is a registered copy of the grantee.
- IDLE:
  - s_read=s_write=0; both waitrequests=1.
  - Arbitration at the clock edge:
    - m1 pending and starve_cnt==MAX_HIGH_GRANTS: grant m1.
    - Else m0_read: grant m0.
    - Else m1_read|m1_write: grant m1.
  - Next state:
    - m0 grant: CMD_READ.
    - m1 grant with m1_read: CMD_READ (read wins if m1 asserts read and write together).
    - m1 grant with write only: WRITE.
  - Latency: request visible in IDLE at cycle N → command on s_* at N+1.
- Starvation counter:
  - Increments on each m0 grant while m1 is pending, saturating at MAX_HIGH_GRANTS.
  - Clears on any m1 grant, or on an m0 grant with m1 idle.
- CMD_READ:
  - s_* driven combinationally from the owner's inputs; the other requester's inputs are ignored.
  - owner_waitrequest = s_waitrequest; non-owner waitrequest = 1.
  - On s_read & !s_waitrequest:
    - Latch beats = s_burstcount (0 treated as 1).
    - Go to DATA_READ.
  - Owner drops read before acceptance (protocol violation): return to IDLE and issue nothing.
- DATA_READ:
  - s_read=0; both waitrequests=1.
  - owner_readdatavalid = s_readdatavalid; non-owner readdatavalid = 0.
  - Each valid beat decrements beats.
  - The valid beat with beats==1 moves the state to IDLE.
- WRITE:
  - s_* passed through from m1; m1_waitrequest = s_waitrequest.
  - First accepted beat latches beats = s_burstcount (0 → 1).
  - Each accepted beat (s_write & !s_waitrequest) decrements.
  - Last accepted beat moves to IDLE.
  - m1_write dropping between beats stalls in WRITE; it does not abort the burst.
- Read data:
  - readdata = s_readdata unconditionally, one shared bus.
  - s_readdatavalid outside DATA_READ (stale after reset) is dropped and reaches neither requester.
- Throughput: bursts are strictly serialized; one dead IDLE cycle between bursts.
- Reset mid-burst: the arbiter returns to IDLE. Requesters are reset by the same signal and must not rely on a partial burst.

Decomposition:
- Package sdram_arbiter_pkg holds:
  - Widths (ADDR_WIDTH, DATA_WIDTH, BURST_WIDTH defaults).
  - State encoding.
  - Owner encoding constants (OWNER_NONE, OWNER_M0, OWNER_M1).
- A single module; no sub-module. The beat counter and starvation counter are small enough to remain inline.

Test Plan:
- m0 read: m0_read at 0x100, burst 8, s_waitrequest low → s_address=0x100 one cycle after request. After 8 s_readdatavalid beats: m0_readdatavalid pulses exactly 8 times, m1_readdatavalid stays 0, owner returns to 00.
- Simultaneous m0 read (burst 4) and m1 write (burst 2) → m0 served first. m1_waitrequest stays 1 until m0's 4th beat; then 2 write beats appear on s_write with m1_writedata/byteenable intact.
- Starvation, MAX_HIGH_GRANTS=4: m0 requests continuously while m1_read is held → grant order m0,m0,m0,m0,m1,m0… and starve_cnt clears after the m1 grant.
- Write backpressure: m1 write burst 4 with s_waitrequest toggling 1,0,1,1,0,0,1,0 → exactly 4 accepted beats and data order preserved.
- Reset mid-burst: assert reset after 3 of 8 read beats → all outputs at reset values asynchronously. The 5 remaining s_readdatavalid beats drive no m*_readdatavalid; the next m1 request is granted normally.
- burstcount=0 read from m1 → treated as 1: one valid beat returns the arbiter to IDLE.
